// File: rtl/reg_file_2r1w_if.sv
// Operand-store bus: one write port and two registered read ports.
// The master drives writes and read requests; the slave returns read data.
interface reg_file_2r1w_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              rd_en_a;
  logic [ADDR_W-1:0] r_addr_a;
  logic [DATA_W-1:0] r_data_a;
  logic              r_valid_a;
  logic              r_hit_a;

  logic              rd_en_b;
  logic [ADDR_W-1:0] r_addr_b;
  logic [DATA_W-1:0] r_data_b;
  logic              r_valid_b;
  logic              r_hit_b;

  modport master (
    output wr_en, w_addr, w_data,
    output rd_en_a, r_addr_a,
    input  r_data_a, r_valid_a, r_hit_a,
    output rd_en_b, r_addr_b,
    input  r_data_b, r_valid_b, r_hit_b
  );

  modport slave (
    input  wr_en, w_addr, w_data,
    input  rd_en_a, r_addr_a,
    output r_data_a, r_valid_a, r_hit_a,
    input  rd_en_b, r_addr_b,
    output r_data_b, r_valid_b, r_hit_b
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Flop-based 2-read/1-write register file, 1-cycle reads, write-first bypass.
// Optional REG_FILE_ZERO_REG_EN: entry 0 reads as zero (hit=1), writes dropped.
module reg_file_2r1w #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic clk,
  input logic clr_n,
  reg_file_2r1w_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;

  logic              wr_ok;
  logic [DATA_W-1:0] nxt_data_a;
  logic              nxt_hit_a;
  logic [DATA_W-1:0] nxt_data_b;
  logic              nxt_hit_b;

  // Qualify the write; address 0 is read-only when the zero register is on.
  always_comb begin
    wr_ok = bus.wr_en;
`ifdef REG_FILE_ZERO_REG_EN
    if (bus.w_addr == '0) wr_ok = 1'b0;
`endif
  end

  // Port A next value: array lookup, overridden by a same-cycle write.
  always_comb begin
    nxt_data_a = mem[bus.r_addr_a];
    nxt_hit_a  = written[bus.r_addr_a];
    if (wr_ok && (bus.w_addr == bus.r_addr_a)) begin
      nxt_data_a = bus.w_data;
      nxt_hit_a  = 1'b1;
    end
`ifdef REG_FILE_ZERO_REG_EN
    if (bus.r_addr_a == '0) begin
      nxt_data_a = '0;
      nxt_hit_a  = 1'b1;
    end
`endif
  end

  // Port B next value: same rules as port A, independent address.
  always_comb begin
    nxt_data_b = mem[bus.r_addr_b];
    nxt_hit_b  = written[bus.r_addr_b];
    if (wr_ok && (bus.w_addr == bus.r_addr_b)) begin
      nxt_data_b = bus.w_data;
      nxt_hit_b  = 1'b1;
    end
`ifdef REG_FILE_ZERO_REG_EN
    if (bus.r_addr_b == '0) begin
      nxt_data_b = '0;
      nxt_hit_b  = 1'b1;
    end
`endif
  end

  // Storage and written flags; clear dominates any write.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written <= '0;
    end else if (wr_ok) begin
      mem[bus.w_addr]     <= bus.w_data;
      written[bus.w_addr] <= 1'b1;
    end
  end

  // Read port A registers; data and hit hold while idle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bus.r_data_a  <= '0;
      bus.r_hit_a   <= 1'b0;
      bus.r_valid_a <= 1'b0;
    end else begin
      bus.r_valid_a <= bus.rd_en_a;
      if (bus.rd_en_a) begin
        bus.r_data_a <= nxt_data_a;
        bus.r_hit_a  <= nxt_hit_a;
      end
    end
  end

  // Read port B registers; data and hit hold while idle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bus.r_data_b  <= '0;
      bus.r_hit_b   <= 1'b0;
      bus.r_valid_b <= 1'b0;
    end else begin
      bus.r_valid_b <= bus.rd_en_b;
      if (bus.rd_en_b) begin
        bus.r_data_b <= nxt_data_b;
        bus.r_hit_b  <= nxt_hit_b;
      end
    end
  end
endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: directed vectors push expected outputs,
// a negedge monitor pops and compares them against both read ports.
module tb_reg_file_2r1w;
  logic clk;
  logic clr_n;
  int   cyc;
  int   n_chk;
  int   n_pass;

  typedef struct {
    int         tgt;
    bit         port;
    bit         v;
    logic [7:0] d;
    bit         h;
  } exp_t;

  exp_t q[$];

  reg_file_2r1w_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  reg_file_2r1w #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation due this cycle, flag stray valids.
  always @(negedge clk) begin
    bit   seen_a;
    bit   seen_b;
    exp_t e;
    logic av;
    logic ah;
    logic [7:0] ad;
    seen_a = 1'b0;
    seen_b = 1'b0;
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      if (e.port) begin
        av = bus.r_valid_b; ad = bus.r_data_b; ah = bus.r_hit_b; seen_b = 1'b1;
      end else begin
        av = bus.r_valid_a; ad = bus.r_data_a; ah = bus.r_hit_a; seen_a = 1'b1;
      end
      n_chk++;
      if (e.tgt == cyc && av === e.v && ad === e.d && ah === e.h) begin
        n_pass++;
      end else begin
        $display("FAIL port_%s cyc %0d (due %0d): got v=%b d=%h h=%b, want v=%b d=%h h=%b",
                 e.port ? "b" : "a", cyc, e.tgt, av, ad, ah, e.v, e.d, e.h);
      end
    end
    if (bus.r_valid_a === 1'b1 && !seen_a) begin
      n_chk++;
      $display("FAIL stray_valid_a cyc %0d: got 1, want no output", cyc);
    end
    if (bus.r_valid_b === 1'b1 && !seen_b) begin
      n_chk++;
      $display("FAIL stray_valid_b cyc %0d: got 1, want no output", cyc);
    end
  end

  task automatic exp_a(input bit v, input logic [7:0] d, input bit h);
    q.push_back('{tgt: cyc + 1, port: 1'b0, v: v, d: d, h: h});
  endtask

  task automatic exp_b(input bit v, input logic [7:0] d, input bit h);
    q.push_back('{tgt: cyc + 1, port: 1'b1, v: v, d: d, h: h});
  endtask

  task automatic drive(input bit c,
                       input bit we, input logic [1:0] wa, input logic [7:0] wd,
                       input bit ra, input logic [1:0] aa,
                       input bit rb, input logic [1:0] ab);
    clr_n        = c;
    bus.wr_en    = we;
    bus.w_addr   = wa;
    bus.w_data   = wd;
    bus.rd_en_a  = ra;
    bus.r_addr_a = aa;
    bus.rd_en_b  = rb;
    bus.r_addr_b = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit z;
`ifdef REG_FILE_ZERO_REG_EN
    z = 1'b1;
`else
    z = 1'b0;
`endif
    cyc    = 0;
    n_chk  = 0;
    n_pass = 0;

    // Clear held two cycles with a write and a read that must be ignored.
    exp_a(0, 8'h00, 0); exp_b(0, 8'h00, 0);
    drive(0, 1, 2'd1, 8'hFF, 1, 2'd1, 0, 2'd0);
    exp_a(0, 8'h00, 0); exp_b(0, 8'h00, 0);
    drive(0, 1, 2'd1, 8'hFF, 1, 2'd1, 0, 2'd0);
    exp_a(1, 8'h00, 0); exp_b(0, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd1, 0, 2'd0);

    // Write then read, then idle hold.
    exp_a(0, 8'h00, 0); exp_b(0, 8'h00, 0);
    drive(1, 1, 2'd2, 8'hBB, 0, 2'd0, 0, 2'd0);
    exp_a(1, 8'hBB, 1); exp_b(0, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd2, 0, 2'd0);
    exp_a(0, 8'hBB, 1); exp_b(0, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0);

    // Bypass on both ports over an older value.
    exp_a(0, 8'hBB, 1); exp_b(0, 8'h00, 0);
    drive(1, 1, 2'd3, 8'h11, 0, 2'd0, 0, 2'd0);
    exp_a(1, 8'hF0, 1); exp_b(1, 8'hF0, 1);
    drive(1, 1, 2'd3, 8'hF0, 1, 2'd3, 1, 2'd3);

    // Independent ports; with the zero register, addr 0 stays zero.
    exp_a(0, 8'hF0, 1); exp_b(0, 8'hF0, 1);
    drive(1, 1, 2'd0, z ? 8'hAA : 8'h5A, 0, 2'd0, 0, 2'd0);
    if (z) begin
      exp_a(1, 8'h77, 1); exp_b(1, 8'h00, 1);
      drive(1, 1, 2'd1, 8'h77, 1, 2'd1, 1, 2'd0);
    end else begin
      exp_a(1, 8'hBB, 1); exp_b(1, 8'h5A, 1);
      drive(1, 0, 2'd0, 8'h00, 1, 2'd2, 1, 2'd0);
    end
    // Back-to-back read keeps valid high.
    exp_a(1, 8'hF0, 1); exp_b(1, 8'hBB, 1);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd3, 1, 2'd2);

    // Clear pulsed between edges only: no effect.
    exp_a(0, 8'hF0, 1); exp_b(0, 8'hBB, 1);
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
    drive(1, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0);
    exp_a(1, 8'hF0, 1); exp_b(1, 8'hBB, 1);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd3, 1, 2'd2);

    // Clear across one edge with reads requested: everything drops.
    exp_a(0, 8'h00, 0); exp_b(0, 8'h00, 0);
    drive(0, 1, 2'd2, 8'h99, 1, 2'd3, 1, 2'd2);
    exp_a(1, 8'h00, 0); exp_b(1, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd3, 1, 2'd2);
    exp_a(1, 8'h00, z); exp_b(1, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 1, 2'd0, 1, 2'd1);
    exp_a(0, 8'h00, z); exp_b(0, 8'h00, 0);
    drive(1, 0, 2'd0, 8'h00, 0, 2'd0, 0, 2'd0);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file: one write port, two independent read ports (A, B).
- Reads are registered, with 1-cycle latency and write-first bypass.
- A per-entry "written" flag tells the reader whether an entry has been loaded since the last clear.
- Successor to the single-port 4x8 register file; used as a small operand store for datapath blocks.

Parameters:
- DATA_W, 8, width of each entry and of the data ports.
- ADDR_W, 2, address width. Depth = 2**ADDR_W entries; depth is derived internally and is not overridable.

Ports:
- clk  in  1  rising-edge clock.
- clr_n  in  1  synchronous active-low clear; sampled on rising edge of clk.
- wr_en  in  1  write enable.
- w_addr  in  ADDR_W  write address.
- w_data  in  DATA_W  write data.
- rd_en_a  in  1  read request, port A.
- r_addr_a  in  ADDR_W  read address, port A.
- r_data_a  out  DATA_W  registered read data, port A.
- r_valid_a  out  1  high for one cycle when r_data_a was updated by a request.
- r_hit_a  out  1  written flag of the entry read; registered with r_data_a.
- rd_en_b, r_addr_b, r_data_b, r_valid_b, r_hit_b: identical to port A, independent.

Behaviour:
- Clear (clr_n=0 at rising edge):
  - all entries become 0 and all written flags become 0;
  - r_data_a, r_data_b, r_valid_a, r_valid_b, r_hit_a, r_hit_b all become 0;
  - any wr_en or rd_en in that cycle is ignored, because clear dominates.
- Clear is synchronous only: asserting clr_n=0 between edges changes nothing until the next rising edge.
- Write (clr_n=1, wr_en=1): mem[w_addr] <= w_data and written[w_addr] <= 1 at the edge.
- Read, port X (clr_n=1, rd_en_x=1), all updated at the edge:
  - r_data_x <= mem[r_addr_x];
  - r_hit_x <= written[r_addr_x];
  - r_valid_x <= 1.
  - Data is therefore visible one cycle after the request.
- Bypass: if wr_en=1 and w_addr==r_addr_x in the same cycle as the read, r_data_x <= w_data and r_hit_x <= 1 (write-first; no stale data).
- Idle (rd_en_x=0): r_data_x and r_hit_x hold their last value; r_valid_x <= 0.
- Both ports may read the same address in the same cycle; both return identical data, including bypass.
- No address wrap or out-of-range case exists: every ADDR_W code maps to an entry.
- Back-to-back reads every cycle are allowed; r_valid_x then stays high continuously.
- Entries are stored in flops (no RAM inference requirement). Reset values are defined for every bit.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - entry 0 is hardwired to zero and writes to w_addr=0 are discarded;
  - reads of address 0 return r_data_x=0 and r_hit_x=1;
  - bypass never applies to address 0.
- Not defined: entry 0 is an ordinary storage entry, behaving like all others.

Test Plan:
- Clear: hold clr_n=0 for 2 cycles with wr_en=1, w_addr=1, w_data=8'hFF, rd_en_a=1 → after release, reading addr 1 gives r_data_a=8'h00, r_hit_a=0, r_valid_a=1 one cycle after the request.
- Write then read: write 8'hBB to addr 2; next cycle rd_en_a=1, r_addr_a=2 → following cycle r_data_a=8'hBB, r_hit_a=1, r_valid_a=1; the cycle after (rd_en_a=0) r_valid_a=0 and r_data_a holds 8'hBB.
- Bypass on both ports: addr 3 holds 8'h11. In one cycle write 8'hF0 to addr 3 with rd_en_a=1, r_addr_a=3 and rd_en_b=1, r_addr_b=3 → next cycle r_data_a=r_data_b=8'hF0, both hits 1.
- Independent ports: addr 0 holds 8'h5A and addr 2 holds 8'hBB; read A=addr 2, B=addr 0 in the same cycle → next cycle r_data_a=8'hBB, r_data_b=8'h5A (macro undefined).
- Synchronous clear mid-operation: pulse clr_n low between edges only → contents unchanged. Hold it low across one edge → all reads return 8'h00 with r_hit=0, and r_valid outputs drop to 0 in the clear cycle.
- REG_FILE_ZERO_REG_EN defined: write 8'hAA to addr 0, then read addr 0 on port B → r_data_b=8'h00, r_hit_b=1. Reading addr 1 with bypass behaves as normal.
